// File: rtl/pipe_hazard_ctrl_pkg.sv
//==============================================================================
// Module   : pipe_hazard_ctrl_pkg
// Purpose  : Shared state encoding, level constants and control bundle for
//            the pipeline hazard sequencer.
// Revision : 1.0
//==============================================================================
`default_nettype none

package pipe_hazard_ctrl_pkg;

  localparam int REG_ADDR_BUS_W = 5;

  localparam logic c_ASSERTED   = 1'b1;
  localparam logic c_DEASSERTED = 1'b0;

  typedef enum logic [2:0] {
    S_RUN      = 3'd0,
    S_MEM_WAIT = 3'd1,
    S_DRAIN    = 3'd2,
    S_HALTED   = 3'd3,
    S_ERR      = 3'd4
  } state_t;

  typedef struct packed {
    logic stall_pc;
    logic stall_if_id;
    logic stall_id_ex;
    logic stall_ex_mem;
    logic flush_if_id;
    logic flush_id_ex;
    logic flush_mem_wb;
    logic pc_redirect;
    logic halt_ack;
    logic mem_err;
  } ctrl_t;

  localparam ctrl_t c_CTRL_IDLE = '0;

  // Whole-pipe freeze while data memory is busy; MEM/WB gets a bubble so a
  // stalled load never writes back twice.
  function automatic ctrl_t mem_freeze();
    ctrl_t c;
    c              = c_CTRL_IDLE;
    c.stall_pc     = c_ASSERTED;
    c.stall_if_id  = c_ASSERTED;
    c.stall_id_ex  = c_ASSERTED;
    c.stall_ex_mem = c_ASSERTED;
    c.flush_mem_wb = c_ASSERTED;
    c.flush_if_id  = c_DEASSERTED;
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
//==============================================================================
// Module   : pipe_hazard_ctrl_if
// Purpose  : Hazard status from the pipeline and stall/flush controls back.
// Revision : 1.0
//==============================================================================
`default_nettype none

interface pipe_hazard_ctrl_if
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_BUS_W
) ();

  logic [REG_ADDR_W-1:0] id_rs1_addr;
  logic [REG_ADDR_W-1:0] id_rs2_addr;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_write_addr;
  logic                  ex_branch_taken;
  logic                  mem_req;
  logic                  mem_ready;
  logic                  halt_req;

  logic stall_pc;
  logic stall_if_id;
  logic stall_id_ex;
  logic stall_ex_mem;
  logic flush_if_id;
  logic flush_id_ex;
  logic flush_mem_wb;
  logic pc_redirect;
  logic halt_ack;
  logic mem_err;

  modport master (
    output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           ex_mem_read, ex_write_addr, ex_branch_taken,
           mem_req, mem_ready, halt_req,
    input  stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
           flush_if_id, flush_id_ex, flush_mem_wb,
           pc_redirect, halt_ack, mem_err
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           ex_mem_read, ex_write_addr, ex_branch_taken,
           mem_req, mem_ready, halt_req,
    output stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
           flush_if_id, flush_id_ex, flush_mem_wb,
           pc_redirect, halt_ack, mem_err
  );

endinterface

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_lu_detect.sv
//==============================================================================
// Module   : hazard_lu_detect
// Purpose  : Combinational load-use compare between EX destination and ID
//            sources; x0 never creates a dependency.
// Revision : 1.0
//==============================================================================
`default_nettype none

module hazard_lu_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  wire logic [REG_ADDR_W-1:0] rs1_addr,
  input  wire logic [REG_ADDR_W-1:0] rs2_addr,
  input  wire logic                  rs1_used,
  input  wire logic                  rs2_used,
  input  wire logic                  ex_mem_read,
  input  wire logic [REG_ADDR_W-1:0] ex_write_addr,
  output logic                       lu
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  always_comb begin
    w_rs1_hit = rs1_used && (rs1_addr == ex_write_addr);
    w_rs2_hit = rs2_used && (rs2_addr == ex_write_addr);
    lu        = ex_mem_read && (ex_write_addr != '0) && (w_rs1_hit || w_rs2_hit);
  end

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
//==============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Stall/flush sequencer for the 5-stage pipeline: load-use bubbles,
//            memory-wait freeze with timeout, branch squash and debug drain.
//            Define PIPE_HAZARD_CTRL_PERF_EN to add saturating perf counters.
// Revision : 1.0
//==============================================================================
`default_nettype none

module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W   = REG_ADDR_BUS_W,
  parameter int MEM_TIMEOUT  = 64,
  parameter int DRAIN_CYCLES = 4
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  parameter int PERF_W       = 32
`endif
) (
  input  wire logic         clk,
  input  wire logic         rst,
  pipe_hazard_ctrl_if.slave hz
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_lu_cnt,
  output logic [PERF_W-1:0] perf_mem_cnt,
  output logic [PERF_W-1:0] perf_br_cnt
`endif
);

  localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [WAIT_W-1:0]  c_WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [DRAIN_W-1:0] c_DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WAIT_W-1:0]    r_wait_cnt;
  logic [WAIT_W-1:0]    w_wait_cnt_nxt;
  logic [DRAIN_W-1:0]   r_drain_cnt;
  logic [DRAIN_W-1:0]   w_drain_cnt_nxt;
  ctrl_t                w_ctrl;
  logic                 w_lu;
  logic                 w_mem_stall;

  hazard_lu_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_lu_detect (
    .rs1_addr      (hz.id_rs1_addr),
    .rs2_addr      (hz.id_rs2_addr),
    .rs1_used      (hz.id_rs1_used),
    .rs2_used      (hz.id_rs2_used),
    .ex_mem_read   (hz.ex_mem_read),
    .ex_write_addr (hz.ex_write_addr),
    .lu            (w_lu)
  );

  assign w_mem_stall = hz.mem_req && !hz.mem_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_RUN;
      r_wait_cnt  <= '0;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
    end
  end

  always_comb begin
    w_ctrl          = c_CTRL_IDLE;
    w_state_nxt     = r_state;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_drain_cnt_nxt = r_drain_cnt;
    case (r_state)
      S_RUN: begin
        if (w_mem_stall) begin
          w_ctrl         = mem_freeze();
          w_state_nxt    = S_MEM_WAIT;
          w_wait_cnt_nxt = WAIT_W'(1);
        end else if (hz.ex_branch_taken) begin
          w_ctrl.pc_redirect = c_ASSERTED;
          w_ctrl.flush_if_id = c_ASSERTED;
          w_ctrl.flush_id_ex = c_ASSERTED;
        end else if (w_lu) begin
          w_ctrl.stall_pc    = c_ASSERTED;
          w_ctrl.stall_if_id = c_ASSERTED;
          w_ctrl.flush_id_ex = c_ASSERTED;
        end else if (hz.halt_req) begin
          w_state_nxt     = S_DRAIN;
          w_drain_cnt_nxt = '0;
        end
      end
      S_MEM_WAIT: begin
        if (hz.mem_ready) begin
          w_state_nxt    = S_RUN;
          w_wait_cnt_nxt = '0;
        end else begin
          w_ctrl = mem_freeze();
          if (r_wait_cnt == c_WAIT_LAST) w_state_nxt = S_ERR;
          else                           w_wait_cnt_nxt = r_wait_cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        if (w_mem_stall) begin
          w_ctrl = mem_freeze();
          if (r_wait_cnt == c_WAIT_LAST) w_state_nxt = S_ERR;
          else                           w_wait_cnt_nxt = r_wait_cnt + 1'b1;
        end else begin
          w_wait_cnt_nxt  = '0;
          w_ctrl.stall_pc = c_ASSERTED;
          // Fetch stays held on a branch so the redirected PC is kept for resume;
          // a load-use bubble holds IF/ID instead of flushing it and pauses the count.
          if (hz.ex_branch_taken) begin
            w_ctrl.pc_redirect = c_ASSERTED;
            w_ctrl.flush_if_id = c_ASSERTED;
            w_ctrl.flush_id_ex = c_ASSERTED;
          end else if (w_lu) begin
            w_ctrl.stall_if_id = c_ASSERTED;
            w_ctrl.flush_id_ex = c_ASSERTED;
          end else begin
            w_ctrl.flush_if_id = c_ASSERTED;
          end
          if (!hz.halt_req) begin
            w_state_nxt     = S_RUN;
            w_drain_cnt_nxt = '0;
          end else if (hz.ex_branch_taken || !w_lu) begin
            if (r_drain_cnt == c_DRAIN_LAST) begin
              w_state_nxt     = S_HALTED;
              w_drain_cnt_nxt = '0;
            end else begin
              w_drain_cnt_nxt = r_drain_cnt + 1'b1;
            end
          end
        end
      end
      S_HALTED: begin
        if (hz.halt_req) begin
          w_ctrl.halt_ack    = c_ASSERTED;
          w_ctrl.stall_pc    = c_ASSERTED;
          w_ctrl.flush_if_id = c_ASSERTED;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_ERR: begin
        w_ctrl         = mem_freeze();
        w_ctrl.mem_err = c_ASSERTED;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  assign hz.stall_pc     = w_ctrl.stall_pc;
  assign hz.stall_if_id  = w_ctrl.stall_if_id;
  assign hz.stall_id_ex  = w_ctrl.stall_id_ex;
  assign hz.stall_ex_mem = w_ctrl.stall_ex_mem;
  assign hz.flush_if_id  = w_ctrl.flush_if_id;
  assign hz.flush_id_ex  = w_ctrl.flush_id_ex;
  assign hz.flush_mem_wb = w_ctrl.flush_mem_wb;
  assign hz.pc_redirect  = w_ctrl.pc_redirect;
  assign hz.halt_ack     = w_ctrl.halt_ack;
  assign hz.mem_err      = w_ctrl.mem_err;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [PERF_W-1:0] r_perf_lu;
  logic [PERF_W-1:0] r_perf_mem;
  logic [PERF_W-1:0] r_perf_br;
  logic              w_perf_lu_cyc;
  logic              w_perf_mem_cyc;

  assign w_perf_lu_cyc  = w_ctrl.flush_id_ex && !w_ctrl.pc_redirect;
  assign w_perf_mem_cyc = (r_state == S_MEM_WAIT) || ((r_state == S_RUN) && w_mem_stall);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_lu  <= '0;
      r_perf_mem <= '0;
      r_perf_br  <= '0;
    end else begin
      if (w_perf_lu_cyc && !(&r_perf_lu))       r_perf_lu  <= r_perf_lu + 1'b1;
      if (w_perf_mem_cyc && !(&r_perf_mem))     r_perf_mem <= r_perf_mem + 1'b1;
      if (w_ctrl.pc_redirect && !(&r_perf_br))  r_perf_br  <= r_perf_br + 1'b1;
    end
  end

  assign perf_lu_cnt  = r_perf_lu;
  assign perf_mem_cnt = r_perf_mem;
  assign perf_br_cnt  = r_perf_br;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
//==============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT=4).
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

  // Output vector order: stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
  // flush_if_id, flush_id_ex, flush_mem_wb, pc_redirect, halt_ack, mem_err
  localparam logic [9:0] c_IDLE   = 10'b0000000000;
  localparam logic [9:0] c_FREEZE = 10'b1111001000;
  localparam logic [9:0] c_LU     = 10'b1100010000;
  localparam logic [9:0] c_BR     = 10'b0000110100;
  localparam logic [9:0] c_DRN    = 10'b1000100000;
  localparam logic [9:0] c_HLT    = 10'b1000100010;
  localparam logic [9:0] c_ERRV   = 10'b1111001001;
  localparam logic [9:0] c_ALL    = 10'h3FF;

  typedef struct {
    logic       mrd;
    logic [4:0] wa;
    logic [4:0] rs1;
    logic       r1u;
    logic [4:0] rs2;
    logic       r2u;
    logic       br;
    logic       mq;
    logic       mr;
    logic       hl;
    logic [9:0] val;
    logic [9:0] mask;
  } step_t;

  typedef struct {
    logic [9:0] val;
    logic [9:0] mask;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t exp_q[$];

  pipe_hazard_ctrl_if #(.REG_ADDR_W(5)) hz ();

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] perf_lu_cnt;
  logic [31:0] perf_mem_cnt;
  logic [31:0] perf_br_cnt;
`endif

  pipe_hazard_ctrl #(
    .REG_ADDR_W   (5),
    .MEM_TIMEOUT  (4),
    .DRAIN_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    .perf_lu_cnt  (perf_lu_cnt),
    .perf_mem_cnt (perf_mem_cnt),
    .perf_br_cnt  (perf_br_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [9:0] outs();
    return {hz.stall_pc, hz.stall_if_id, hz.stall_id_ex, hz.stall_ex_mem,
            hz.flush_if_id, hz.flush_id_ex, hz.flush_mem_wb,
            hz.pc_redirect, hz.halt_ack, hz.mem_err};
  endfunction

  function automatic step_t stp(input logic [9:0] val, input logic [9:0] mask,
                                input logic mrd, input logic [4:0] wa,
                                input logic [4:0] rs1, input logic r1u,
                                input logic [4:0] rs2, input logic r2u,
                                input logic br, input logic mq, input logic mr,
                                input logic hl);
    step_t s;
    s.val = val; s.mask = mask; s.mrd = mrd; s.wa = wa;
    s.rs1 = rs1; s.r1u = r1u; s.rs2 = rs2; s.r2u = r2u;
    s.br = br; s.mq = mq; s.mr = mr; s.hl = hl;
    return s;
  endfunction

  task automatic apply(input step_t s);
    hz.ex_mem_read     = s.mrd;
    hz.ex_write_addr   = s.wa;
    hz.id_rs1_addr     = s.rs1;
    hz.id_rs1_used     = s.r1u;
    hz.id_rs2_addr     = s.rs2;
    hz.id_rs2_used     = s.r2u;
    hz.ex_branch_taken = s.br;
    hz.mem_req         = s.mq;
    hz.mem_ready       = s.mr;
    hz.halt_req        = s.hl;
  endtask

  task automatic test_reset();
    logic [9:0] got;
    rst = 1'b0;
    apply(stp(c_IDLE, c_ALL, 0,0, 0,0, 0,0, 0,0,0,0));
    @(negedge clk);
    got = outs();
    total++;
    if (got !== c_IDLE) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=%b", got, c_IDLE);
    end
    rst = 1'b1;
  endtask

  task automatic test_load_use();
    step_t s[$];
    exp_t  e;
    logic [9:0] got;
    s.push_back(stp(c_LU,   c_ALL, 1,5,  3,1, 5,1,  0,0,0,0));
    s.push_back(stp(c_IDLE, c_ALL, 0,0,  3,1, 5,1,  0,0,0,0));
    s.push_back(stp(c_LU,   c_ALL, 1,7,  7,1, 2,0,  0,0,0,0));
    s.push_back(stp(c_IDLE, c_ALL, 1,7,  7,0, 2,0,  0,0,0,0));
    s.push_back(stp(c_IDLE, c_ALL, 1,0,  0,1, 0,1,  0,0,0,0));
    s.push_back(stp(c_IDLE, c_ALL, 1,9,  8,1, 10,1, 0,0,0,0));
    foreach (s[i]) begin
      @(posedge clk); #1;
      apply(s[i]);
      exp_q.push_back('{val: s[i].val, mask: s[i].mask});
      @(negedge clk);
      e = exp_q.pop_front();
      got = outs();
      total++;
      if ((got & e.mask) !== (e.val & e.mask)) begin
        bad++;
        $display("FAIL load_use step%0d got=%b want=%b", i, got, e.val);
      end
    end
  endtask

  task automatic test_branch_vs_lu();
    step_t s[$];
    exp_t  e;
    logic [9:0] got;
    s.push_back(stp(c_BR,   c_ALL, 1,5, 5,1, 0,0, 1,0,0,0));
    s.push_back(stp(c_BR,   c_ALL, 0,0, 0,0, 0,0, 1,0,0,0));
    s.push_back(stp(c_BR,   c_ALL, 0,0, 0,0, 0,0, 1,0,0,1));
    s.push_back(stp(c_IDLE, c_ALL, 0,0, 0,0, 0,0, 0,0,0,0));
    foreach (s[i]) begin
      @(posedge clk); #1;
      apply(s[i]);
      exp_q.push_back('{val: s[i].val, mask: s[i].mask});
      @(negedge clk);
      e = exp_q.pop_front();
      got = outs();
      total++;
      if ((got & e.mask) !== (e.val & e.mask)) begin
        bad++;
        $display("FAIL branch_vs_lu step%0d got=%b want=%b", i, got, e.val);
      end
    end
  endtask

  task automatic test_mem_wait();
    step_t s[$];
    exp_t  e;
    logic [9:0] got;
    s.push_back(stp(c_FREEZE, c_ALL, 0,0, 0,0, 0,0, 1,1,0,0));
    s.push_back(stp(c_FREEZE, c_ALL, 0,0, 0,0, 0,0, 1,1,0,0));
    s.push_back(stp(c_FREEZE, c_ALL, 0,0, 0,0, 0,0, 1,1,0,0));
    s.push_back(stp(c_IDLE,   c_ALL, 0,0, 0,0, 0,0, 1,1,1,0));
    s.push_back(stp(c_BR,     c_ALL, 0,0, 0,0, 0,0, 1,0,0,0));
    s.push_back(stp(c_IDLE,   c_ALL, 0,0, 0,0, 0,0, 0,0,0,0));
    foreach (s[i]) begin
      @(posedge clk); #1;
      apply(s[i]);
      exp_q.push_back('{val: s[i].val, mask: s[i].mask});
      @(negedge clk);
      e = exp_q.pop_front();
      got = outs();
      total++;
      if ((got & e.mask) !== (e.val & e.mask)) begin
        bad++;
        $display("FAIL mem_wait step%0d got=%b want=%b", i, got, e.val);
      end
    end
  endtask

  task automatic test_halt();
    step_t s[$];
    exp_t  e;
    logic [9:0] got;
    // plain drain: four DRAIN cycles, then ack until the request falls
    s.push_back(stp(c_IDLE, c_ALL, 0,0, 0,0, 0,0, 0,0,0,1));
    repeat (4) s.push_back(stp(c_DRN, c_ALL, 0,0, 0,0, 0,0, 0,0,0,1));
    s.push_back(stp(c_HLT,  c_ALL, 0,0, 0,0, 0,0, 0,0,0,1));
    s.push_back(stp(c_IDLE, c_ALL, 0,0, 0,0, 0,0, 0,0,0,0));
    s.push_back(stp(c_LU,   c_ALL, 1,5, 5,1, 0,0, 0,0,0,0));
    // drain with one inserted memory-wait cycle
    s.push_back(stp(c_IDLE,   c_ALL, 0,0, 0,0, 0,0, 0,0,0,1));
    s.push_back(stp(c_DRN,    c_ALL, 0,0, 0,0, 0,0, 0,0,0,1));
    s.push_back(stp(c_FREEZE, c_ALL, 0,0, 0,0, 0,0, 0,1,0,1));
    repeat (3) s.push_back(stp(c_DRN, c_ALL, 0,0, 0,0, 0,0, 0,0,0,1));
    s.push_back(stp(c_HLT,  c_ALL, 0,0, 0,0, 0,0, 0,0,0,1));
    s.push_back(stp(c_IDLE, c_ALL, 0,0, 0,0, 0,0, 0,0,0,0));
    // branch inside drain, then abort before completion
    s.push_back(stp(c_IDLE, c_ALL, 0,0, 0,0, 0,0, 0,0,0,1));
    s.push_back(stp(c_DRN,  c_ALL, 0,0, 0,0, 0,0, 0,0,0,1));
    s.push_back(stp(10'b1000000100, 10'b1000000110, 0,0, 0,0, 0,0, 1,0,0,1));
    s.push_back(stp(c_IDLE, 10'b0000000010, 0,0, 0,0, 0,0, 0,0,0,0));
    s.push_back(stp(c_IDLE, c_ALL, 0,0, 0,0, 0,0, 0,0,0,0));
    foreach (s[i]) begin
      @(posedge clk); #1;
      apply(s[i]);
      exp_q.push_back('{val: s[i].val, mask: s[i].mask});
      @(negedge clk);
      e = exp_q.pop_front();
      got = outs();
      total++;
      if ((got & e.mask) !== (e.val & e.mask)) begin
        bad++;
        $display("FAIL halt step%0d got=%b want=%b", i, got, e.val);
      end
    end
  endtask

  task automatic test_timeout();
    step_t s[$];
    exp_t  e;
    logic [9:0] got;
    repeat (4) s.push_back(stp(c_FREEZE, c_ALL, 0,0, 0,0, 0,0, 0,1,0,0));
    s.push_back(stp(c_ERRV, c_ALL, 0,0, 0,0, 0,0, 0,1,0,0));
    s.push_back(stp(c_ERRV, c_ALL, 0,0, 0,0, 0,0, 0,0,1,0));
    s.push_back(stp(c_ERRV, c_ALL, 0,0, 0,0, 0,0, 0,0,0,0));
    foreach (s[i]) begin
      @(posedge clk); #1;
      apply(s[i]);
      exp_q.push_back('{val: s[i].val, mask: s[i].mask});
      @(negedge clk);
      e = exp_q.pop_front();
      got = outs();
      total++;
      if ((got & e.mask) !== (e.val & e.mask)) begin
        bad++;
        $display("FAIL timeout step%0d got=%b want=%b", i, got, e.val);
      end
    end
    // asynchronous reset clears ERR without waiting for a clock edge
    #2 rst = 1'b0;
    #1;
    got = outs();
    total++;
    if (got !== c_IDLE) begin
      bad++;
      $display("FAIL timeout_async_reset got=%b want=%b", got, c_IDLE);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    apply(stp(c_LU, c_ALL, 1,5, 5,1, 0,0, 0,0,0,0));
    exp_q.push_back('{val: c_LU, mask: c_ALL});
    @(negedge clk);
    e = exp_q.pop_front();
    got = outs();
    total++;
    if ((got & e.mask) !== (e.val & e.mask)) begin
      bad++;
      $display("FAIL timeout_after_reset got=%b want=%b", got, e.val);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_load_use();
    test_branch_vs_lu();
    test_mem_wait();
    test_halt();
    test_timeout();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline (IF, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Detects load-use hazards, freezes the pipe while data memory is busy, and squashes wrong-path instructions on a taken branch.
- Drains and holds the pipe for a debug halt request.
- Drives hold/bubble enables of every pipeline register, including MEM/WB, whose bubble clears the write-back control bits (RegWrite, Mem2Reg).

Parameters:
- REG_ADDR_W, 5, register address width.
- MEM_TIMEOUT, 64, data-memory wait cycles before an error is flagged (>=2).
- DRAIN_CYCLES, 4, bubble cycles needed to empty IF/ID..MEM/WB.
- PERF_W, 32, performance counter width (optional feature only).

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous active-low reset.
- id_rs1_addr  in  REG_ADDR_W  rs1 of instruction in ID.
- id_rs2_addr  in  REG_ADDR_W  rs2 of instruction in ID.
- id_rs1_used  in  1  ID instruction reads rs1.
- id_rs2_used  in  1  ID instruction reads rs2.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_write_addr  in  REG_ADDR_W  destination of instruction in EX.
- ex_branch_taken  in  1  EX resolved a taken branch/jump.
- mem_req  in  1  MEM stage is accessing data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- halt_req  in  1  debug halt request, level.
- stall_pc  out  1  hold PC.
- stall_if_id  out  1  hold IF/ID.
- stall_id_ex  out  1  hold ID/EX.
- stall_ex_mem  out  1  hold EX/MEM.
- flush_if_id  out  1  load bubble into IF/ID.
- flush_id_ex  out  1  load bubble into ID/EX.
- flush_mem_wb  out  1  load bubble into MEM/WB (RegWrite=0, Mem2Reg=0).
- pc_redirect  out  1  PC takes branch target.
- halt_ack  out  1  pipe drained and halted.
- mem_err  out  1  sticky memory timeout.

Behaviour:
- FSM states: RUN, MEM_WAIT, DRAIN, HALTED, ERR. Reset state is RUN.
- Reset: all outputs 0, wait counter 0, drain counter 0.
- Load-use (lu) = ex_mem_read & ex_write_addr!=0 & ((id_rs1_used & rs1==ex_write_addr) | (id_rs2_used & rs2==ex_write_addr)).
- Stall detection is combinational with zero latency; state updates on the posedge.
- RUN, priority order:
  1. mem_req & !mem_ready: set stall_pc, stall_if_id, stall_id_ex, stall_ex_mem and flush_mem_wb this cycle; next state MEM_WAIT; counter=1.
  2. Else ex_branch_taken: pc_redirect=1, flush_if_id=1, flush_id_ex=1.
  3. Else lu: stall_pc=1, stall_if_id=1, flush_id_ex=1, for exactly one bubble.
  4. Else if halt_req: next state DRAIN.
- A branch and lu in the same cycle resolve as the branch; lu is ignored because the ID instruction is squashed.
- MEM_WAIT: same stall/flush outputs as RUN case 1, every cycle. Counter increments each cycle.
  - On mem_ready: outputs drop to 0 in that same cycle, EX/MEM advances, and the next state is RUN. A branch or lu pending in EX is then evaluated in RUN on the following cycle.
  - If the counter reaches MEM_TIMEOUT without mem_ready: next state ERR.
- ERR: mem_err=1; all stalls held at 1 and flush_mem_wb=1. Only reset exits ERR.
- DRAIN: stall_pc=1, flush_if_id=1; the stages behind keep flowing. The drain counter counts DRAIN_CYCLES.
  - Memory waits inside DRAIN stall as in MEM_WAIT and do not advance the counter.
  - A taken branch during DRAIN asserts pc_redirect but fetch stays held, so the new PC is latched for resume.
  - When the count completes: next state HALTED.
- HALTED: halt_ack=1, stall_pc=1, flush_if_id=1. When halt_req falls: next state RUN, halt_ack drops the same cycle.
- halt_req dropped during DRAIN: return to RUN next cycle, with no ack.
- Reset mid-operation: asynchronous clear to RUN; any in-flight bubble is abandoned.

Optional Feature:
- Macro: PIPE_HAZARD_CTRL_PERF_EN.
- Defined: adds outputs perf_lu_cnt, perf_mem_cnt and perf_br_cnt, each PERF_W wide.
  - They count lu-bubble cycles, MEM_WAIT cycles (including the entry cycle) and branch flushes.
  - Counters saturate at all-ones and clear on reset.
- Not defined: ports and logic absent.

Decomposition:
- Shared defines/package: state encoding constants, and the Asserted/Deasserted style level constants.
- REG_ADDR_W comes from the common RegAddrBus width.
- One natural sub-module: hazard_lu_detect, a purely combinational lu compare. The FSM and counters stay in the top.

Test Plan:
- Load-use: load x5 in EX, ID add reads rs2=x5 (rs2_used=1) -> one cycle of stall_pc=stall_if_id=flush_id_ex=1, then all 0.
- x0 load: load with ex_write_addr=0 against ID rs1=0 -> no stall.
- Memory wait: mem_req=1 and mem_ready=0 for 3 cycles, then 1 -> stalls and flush_mem_wb high for 3 cycles; 0 on the ready cycle.
- Timeout: MEM_TIMEOUT=4, mem_ready never rises -> mem_err=1 after 4 wait cycles; remains 1 until rst low.
- Branch vs load-use together: ex_branch_taken=1 while lu is true -> pc_redirect=flush_if_id=flush_id_ex=1, stall_pc=0.
- Halt: halt_req=1 in RUN -> halt_ack rises after 4 DRAIN cycles (5 with one inserted memory-wait cycle); halt_req=0 -> halt_ack=0 the same cycle, RUN next.
